// File: rtl/mat_pkg.sv
// Shared types and constants for the 3x3 signed-nibble matrix operand path.
// Element (r,c) of a packed matrix word lives at bit offset ELEM_W*(N*r+c).
package mat_pkg;

    localparam int ELEM_W   = 4;
    localparam int N        = 3;
    localparam int MAT_W    = N * N * ELEM_W;
    localparam int IDX_W    = 4;
    localparam int LAST_IDX = N * N - 1;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_e;

    function automatic logic [5:0] slot_lsb(input logic [IDX_W-1:0] idx);
        return 6'(ELEM_W) * {2'b00, idx};
    endfunction

endpackage

// File: rtl/mat_elem_reg.sv
// Nine-slot write-indexed element register file with a flat packed matrix output.
// Latency: a write is visible on mat_o the cycle after wr_en_i.
// Backpressure: none; every write is taken.
module mat_elem_reg
    import mat_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [ELEM_W-1:0] wr_dat_i,
    output logic [MAT_W-1:0]  mat_o
);

    logic [MAT_W-1:0] mat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_q <= '0;
        end else if (wr_en_i) begin
            mat_q[slot_lsb(wr_idx_i) +: ELEM_W] <= wr_dat_i;
        end
    end

    assign mat_o = mat_q;

endmodule

// File: rtl/mat_operand_loader.sv
// Packs a serial stream of 18 signed nibbles (A then B, row-major) into an operand pair.
// Latency: out_valid rises the cycle after the 18th accept; 19-cycle minimum frame period.
// Backpressure: in_ready drops while a pair is held; optional abort via MAT_OPERAND_LOADER_ABORT_EN.
module mat_operand_loader
    import mat_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef MAT_OPERAND_LOADER_ABORT_EN
    input  logic              abort,
`endif
    output logic [MAT_W-1:0]  a_out,
    output logic [MAT_W-1:0]  b_out,
    output logic              err
);

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               err_q;
    logic [MAT_W-1:0]   a_out_q;
    logic [MAT_W-1:0]   b_out_q;

    logic               abort_w;
    logic               accept;
    logic               idx_last;
    logic               a_wr;
    logic               b_wr;
    logic [MAT_W-1:0]   a_mat;
    logic [MAT_W-1:0]   b_mat;

`ifdef MAT_OPERAND_LOADER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign accept   = in_valid && in_ready_q && !abort_w;
    assign idx_last = (idx_q == IDX_W'(LAST_IDX));
    assign a_wr     = accept && (state_q == LOAD_A);
    assign b_wr     = accept && (state_q == LOAD_B);

    mat_elem_reg u_a_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (a_wr),
        .wr_idx_i (idx_q),
        .wr_dat_i (in_data),
        .mat_o    (a_mat)
    );

    mat_elem_reg u_b_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (b_wr),
        .wr_idx_i (idx_q),
        .wr_dat_i (in_data),
        .mat_o    (b_mat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            a_out_q     <= '0;
            b_out_q     <= '0;
        end else begin
            err_q <= 1'b0;
            if (abort_w) begin
                state_q     <= LOAD_A;
                idx_q       <= '0;
                out_valid_q <= 1'b0;
                in_ready_q  <= 1'b1;
            end else begin
                case (state_q)
                    LOAD_A: begin
                        in_ready_q <= 1'b1;
                        if (accept) begin
                            if (in_last) begin
                                err_q <= 1'b1;
                                idx_q <= '0;
                            end else if (idx_last) begin
                                state_q <= LOAD_B;
                                idx_q   <= '0;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                    end
                    LOAD_B: begin
                        in_ready_q <= 1'b1;
                        if (accept) begin
                            if (idx_last && in_last) begin
                                // Final B slot bypasses its shadow so the pair lands in one edge.
                                state_q     <= HOLD;
                                idx_q       <= '0;
                                in_ready_q  <= 1'b0;
                                out_valid_q <= 1'b1;
                                a_out_q     <= a_mat;
                                b_out_q     <= {in_data, b_mat[MAT_W-ELEM_W-1:0]};
                            end else if (idx_last || in_last) begin
                                state_q <= LOAD_A;
                                idx_q   <= '0;
                                err_q   <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (out_ready) begin
                            state_q     <= LOAD_A;
                            idx_q       <= '0;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= LOAD_A;
                        idx_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign a_out     = a_out_q;
    assign b_out     = b_out_q;

endmodule

// File: tb/tb_mat_operand_loader.sv
// Directed and randomized bench for mat_operand_loader against a frame-level reference model.
module tb_mat_operand_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_data = 4'h0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [35:0] a_out;
    logic [35:0] b_out;
    logic        err;
`ifdef MAT_OPERAND_LOADER_ABORT_EN
    logic        abort = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: elements of the current frame plus expected visible outputs.
    logic [3:0]  frame_q[$];
    logic [35:0] exp_a = '0;
    logic [35:0] exp_b = '0;
    logic        exp_err = 1'b0;
    logic        exp_done = 1'b0;

    always #5 clk = ~clk;

    mat_operand_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef MAT_OPERAND_LOADER_ABORT_EN
        .abort     (abort),
`endif
        .a_out     (a_out),
        .b_out     (b_out),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [35:0] pack(input int base);
        logic [35:0] v;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[4*(3*r+c) +: 4] = frame_q[base + 3*r + c];
        return v;
    endfunction

    task automatic model_accept(input logic [3:0] d, input logic last);
        int n;
        frame_q.push_back(d);
        n = frame_q.size();
        exp_err  = 1'b0;
        exp_done = 1'b0;
        if ((last && n != 18) || (n == 18 && !last)) begin
            exp_err = 1'b1;
            frame_q.delete();
        end else if (n == 18) begin
            exp_a = pack(0);
            exp_b = pack(9);
            exp_done = 1'b1;
            frame_q.delete();
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_err"},   36'(err),       36'(exp_err));
        chk({tag, "_valid"}, 36'(out_valid), 36'(exp_done));
        chk({tag, "_a"},     a_out,          exp_a);
        chk({tag, "_b"},     b_out,          exp_b);
    endtask

    // Offer one element, wait (bounded) for the handshake, then check against the model.
    task automatic send(input logic [3:0] d, input logic last, input int gap);
        bit taken;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        taken = 1'b0;
        for (int t = 0; t < 200 && !taken; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                taken = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!taken) begin
            checks++;
            failures++;
            $error("FAIL accept_timeout observed=no_ready expected=ready");
        end else begin
            model_accept(d, last);
            check_outputs("accept");
        end
    endtask

    task automatic send_frame(input int max_gap);
        for (int i = 0; i < 18; i++)
            send(4'($urandom), i == 17, int'($urandom_range(0, max_gap)));
    endtask

    initial begin
        logic [35:0] held_a;
        logic [35:0] held_b;

        #3;
        chk("rst_valid", 36'(out_valid), 36'd0);
        chk("rst_ready", 36'(in_ready),  36'd0);
        chk("rst_err",   36'(err),       36'd0);
        chk("rst_a",     a_out,          36'd0);
        chk("rst_b",     b_out,          36'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_lo", 36'(in_ready), 36'd0);
        @(posedge clk);
        #1;
        chk("rel_ready_hi", 36'(in_ready), 36'd1);

        // Counting pattern for A, all -1 for B, held in HOLD by out_ready low.
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(4'(i + 1), 1'b0, 0);
        for (int i = 0; i < 9; i++) send(4'hF, i == 8, 0);
        chk("ref_a", a_out, 36'h987654321);
        chk("ref_b", b_out, 36'hFFFFFFFFF);

        in_valid = 1'b1;
        in_data  = 4'h7;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_ready", 36'(in_ready),  36'd0);
            chk("hold_valid", 36'(out_valid), 36'd1);
            chk("hold_a",     a_out,          36'h987654321);
            chk("hold_b",     b_out,          36'hFFFFFFFFF);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("release_valid", 36'(out_valid), 36'd0);
        chk("release_ready", 36'(in_ready),  36'd1);
        exp_done = 1'b0;

        // in_last on the 5th element.
        for (int i = 0; i < 5; i++) send(4'($urandom), i == 4, 0);
        @(posedge clk);
        #1;
        chk("err_clear", 36'(err), 36'd0);
        send_frame(0);

        // 18th element without in_last.
        for (int i = 0; i < 18; i++) send(4'($urandom), 1'b0, 0);
        send_frame(1);

        // Asynchronous reset after 10 accepts.
        for (int i = 0; i < 10; i++) send(4'($urandom), 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a",     a_out,           36'd0);
        chk("mid_rst_b",     b_out,           36'd0);
        chk("mid_rst_valid", 36'(out_valid),  36'd0);
        chk("mid_rst_ready", 36'(in_ready),   36'd0);
        chk("mid_rst_err",   36'(err),        36'd0);
        frame_q.delete();
        exp_a = '0;
        exp_b = '0;
        exp_err = 1'b0;
        exp_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(0);

`ifdef MAT_OPERAND_LOADER_ABORT_EN
        // Abort with an element on offer at B idx 4; that element must be dropped.
        held_a = exp_a;
        held_b = exp_b;
        for (int i = 0; i < 13; i++) send(4'($urandom), 1'b0, 0);
        in_valid = 1'b1;
        in_data  = 4'hA;
        abort    = 1'b1;
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_err",   36'(err),       36'd0);
        chk("abort_ready", 36'(in_ready),  36'd1);
        chk("abort_valid", 36'(out_valid), 36'd0);
        chk("abort_a",     a_out,          held_a);
        chk("abort_b",     b_out,          held_b);
        frame_q.delete();
        exp_err = 1'b0;
        send_frame(0);
`endif

        // Random frames with idle gaps and a random error mixed in.
        for (int f = 0; f < 4; f++) begin
            if ($urandom_range(0, 1) == 1)
                for (int i = 0; i < int'($urandom_range(1, 17)); i++)
                    send(4'($urandom), $urandom_range(0, 3) == 0, int'($urandom_range(0, 2)));
            send_frame(2);
        end

        held_a = a_out;
        held_b = b_out;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_a", a_out, held_a);
        chk("idle_b", b_out, held_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
